fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch front end with a one-entry skid buffer,
// a pending-redirect register for redirects that arrive while a request is
// outstanding, and a halt path that drains the outstanding request.
// Optional feature: define PC_MISALIGN_TRAP_EN to send misaligned redirects
// to TRAP_VECTOR and pulse misalign_trap. When it is undefined, the low two
// target bits are ignored and misalign_trap stays 0.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] pc_out,
  output logic        misalign_trap
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        halting_q, halting_d;
  logic [31:0] skid_q, skid_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        trap_q, trap_d;

  logic        misaligned;
  logic [31:0] redir_target;
  logic        halt_eff;
  logic        redir_acc;

`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned   = |redirect_pc[1:0];
  assign redir_target = misaligned ? TRAP_VECTOR : redirect_pc;
`else
  assign misaligned   = 1'b0;
  assign redir_target = redirect_pc & ~32'h0000_0003;
`endif

  // A halt seen earlier keeps its effect until the outstanding request drains.
  assign halt_eff  = halt | halting_q;
  assign redir_acc = redirect_valid && (state_q != HALTED) && !halt_eff;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic: halt outranks redirect, redirect outranks stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (halt_eff)                  state_d = imem_ack ? HALTED : FETCH;
        else if (redir_acc)            state_d = FETCH;
        else if (imem_ack && pend_q)   state_d = FETCH;
        else if (imem_ack && stall)    state_d = HOLD;
        else                           state_d = FETCH;
      end
      HOLD: begin
        if (halt_eff)                  state_d = HALTED;
        else if (redir_acc || !stall)  state_d = FETCH;
        else                           state_d = HOLD;
      end
      default:                         state_d = HALTED;
    endcase
  end

  // Output logic: request only while fetching and never during reset.
  always_comb begin
    imem_req  = (state_q == FETCH) && !rst;
    imem_addr = pc_q;
  end

  // Datapath next values: PC, pending redirect, skid buffer and IF/ID entry.
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    halting_d  = halting_q;
    skid_d     = skid_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    trap_d     = redir_acc & misaligned;
    case (state_q)
      FETCH: begin
        if (halt_eff) begin
          // Drain the outstanding request, then drop its response.
          if (imem_ack) begin
            halting_d  = 1'b0;
            pend_d     = 1'b0;
            if_valid_d = 1'b0;
          end else begin
            halting_d  = 1'b1;
          end
        end else if (redir_acc) begin
          if_valid_d = 1'b0;
          if (imem_ack) begin
            pc_d   = redir_target;
            pend_d = 1'b0;
          end else begin
            pend_d    = 1'b1;
            pend_pc_d = redir_target;
          end
        end else if (imem_ack && pend_q) begin
          // Response belongs to the flushed path.
          pc_d   = pend_pc_q;
          pend_d = 1'b0;
          if (!stall) if_valid_d = 1'b0;
        end else if (imem_ack && stall) begin
          skid_d = imem_rdata;
        end else if (imem_ack) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = imem_rdata;
          pc_d       = pc_q + 32'd4;
        end else if (!stall) begin
          if_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (halt_eff) begin
          if_valid_d = 1'b0;
        end else if (redir_acc) begin
          if_valid_d = 1'b0;
          pc_d       = redir_target;
        end else if (!stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = skid_q;
          pc_d       = pc_q + 32'd4;
        end
      end
      default: begin
        if_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0;
      halting_q  <= 1'b0;
      skid_q     <= 32'h0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP;
      trap_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      halting_q  <= halting_d;
      skid_q     <= skid_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      trap_q     <= trap_d;
    end
  end

  assign if_valid      = if_valid_q;
  assign if_pc         = if_pc_q;
  assign if_instr      = if_instr_q;
  assign pc_out        = pc_q;
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, streaming fetch, stall/skid,
// redirect with and without an outstanding request, halt, PC wrap and
// misaligned redirect targets.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] pc_out;
  logic        misalign_trap;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .pc_out        (pc_out),
    .misalign_trap (misalign_trap)
  );

  always #5 clk = ~clk;

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present an ack (with the word for the current address) and advance one cycle.
  task automatic step(input logic ack);
    imem_ack   = ack;
    imem_rdata = ack ? word(imem_addr) : 32'h0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    halt = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;

    // Reset state; stray inputs must be overridden by rst.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0500; stall = 1'b1;
    step(1'b1);
    step(1'b1);
    chk("rst_req",   {31'h0, imem_req}, 32'd0);
    chk("rst_valid", {31'h0, if_valid}, 32'd0);
    chk("rst_ifpc",  if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    chk("rst_pc",    pc_out, 32'h0);
    chk("rst_trap",  {31'h0, misalign_trap}, 32'd0);
    redirect_valid = 1'b0; stall = 1'b0; imem_ack = 1'b0;

    // Streaming fetch with single-cycle acks.
    rst = 1'b0;
    #1;
    chk("first_req",  {31'h0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step(1'b1);
    chk("s0_valid", {31'h0, if_valid}, 32'd1);
    chk("s0_ifpc",  if_pc, 32'h0);
    chk("s0_instr", if_instr, word(32'h0));
    chk("s0_addr",  imem_addr, 32'h4);
    step(1'b1);
    chk("s1_ifpc",  if_pc, 32'h4);
    chk("s1_addr",  imem_addr, 32'h8);

    // Stall coinciding with the ack at 8: three stalled cycles in HOLD.
    stall = 1'b1;
    step(1'b1);
    chk("h1_req",   {31'h0, imem_req}, 32'd0);
    chk("h1_ifpc",  if_pc, 32'h4);
    chk("h1_valid", {31'h0, if_valid}, 32'd1);
    chk("h1_pc",    pc_out, 32'h8);
    step(1'b0);
    chk("h2_req",   {31'h0, imem_req}, 32'd0);
    step(1'b0);
    chk("h3_req",   {31'h0, imem_req}, 32'd0);
    chk("h3_ifpc",  if_pc, 32'h4);
    stall = 1'b0;
    step(1'b0);
    chk("rel_ifpc",  if_pc, 32'h8);
    chk("rel_instr", if_instr, word(32'h8));
    chk("rel_valid", {31'h0, if_valid}, 32'd1);
    chk("rel_addr",  imem_addr, 32'hC);
    chk("rel_req",   {31'h0, imem_req}, 32'd1);

    // Redirect while the request to 0x10 is outstanding.
    step(1'b1);
    chk("c_ifpc", if_pc, 32'hC);
    chk("c_addr", imem_addr, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step(1'b0);
    redirect_valid = 1'b0;
    chk("pr_valid", {31'h0, if_valid}, 32'd0);
    chk("pr_addr",  imem_addr, 32'h10);
    step(1'b0);
    chk("pr_hold",  imem_addr, 32'h10);
    step(1'b1);
    chk("pr_drop",  {31'h0, if_valid}, 32'd0);
    chk("pr_tgt",   imem_addr, 32'h100);
    step(1'b1);
    chk("pr_ifpc",  if_pc, 32'h100);
    chk("pr_instr", if_instr, word(32'h100));

    // Redirect to 0x20 with same-cycle ack, then halt there.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
    step(1'b1);
    redirect_valid = 1'b0;
    chk("rd_valid", {31'h0, if_valid}, 32'd0);
    chk("rd_addr",  imem_addr, 32'h20);
    halt = 1'b1;
    step(1'b1);
    halt = 1'b0;
    chk("hl_req",   {31'h0, imem_req}, 32'd0);
    chk("hl_valid", {31'h0, if_valid}, 32'd0);
    chk("hl_pc",    pc_out, 32'h20);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step(1'b1);
    step(1'b0);
    redirect_valid = 1'b0;
    chk("hl2_req",   {31'h0, imem_req}, 32'd0);
    chk("hl2_valid", {31'h0, if_valid}, 32'd0);
    chk("hl2_pc",    pc_out, 32'h20);

    // Reset out of HALTED, then redirect near the top of the address space.
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    #1;
    chk("r2_addr", imem_addr, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1'b1);
    redirect_valid = 1'b0;
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b1);
    chk("w_ifpc", if_pc, 32'hFFFF_FFFC);
    chk("w_wrap", imem_addr, 32'h0);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step(1'b1);
    redirect_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_addr", imem_addr, 32'h4);
    chk("mis_trap", {31'h0, misalign_trap}, 32'd1);
`else
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_trap", {31'h0, misalign_trap}, 32'd0);
`endif
    chk("mis_valid", {31'h0, if_valid}, 32'd0);
    step(1'b0);
    chk("mis_pulse", {31'h0, misalign_trap}, 32'd0);

    // Redirect wins over stall while in HOLD.
    stall = 1'b1;
    step(1'b1);
    chk("hr_req", {31'h0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step(1'b0);
    redirect_valid = 1'b0;
    chk("hr_req2",  {31'h0, imem_req}, 32'd1);
    chk("hr_addr",  imem_addr, 32'h200);
    chk("hr_valid", {31'h0, if_valid}, 32'd0);
    stall = 1'b0;
    step(1'b1);
    chk("hr_ifpc",  if_pc, 32'h200);
    chk("hr_vld",   {31'h0, if_valid}, 32'd1);

    // Halt with a request outstanding: wait for its ack, then stop.
    chk("ho_addr", imem_addr, 32'h204);
    halt = 1'b1;
    step(1'b0);
    halt = 1'b0;
    chk("ho_req1",  {31'h0, imem_req}, 32'd1);
    chk("ho_addr1", imem_addr, 32'h204);
    step(1'b0);
    chk("ho_req2",  {31'h0, imem_req}, 32'd1);
    step(1'b1);
    chk("ho_req3",  {31'h0, imem_req}, 32'd0);
    chk("ho_valid", {31'h0, if_valid}, 32'd0);
    chk("ho_pc",    pc_out, 32'h204);
    chk("ho_ifpc",  if_pc, 32'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
